// File: rtl/rtc_bus_arbiter.sv
// Arbitrates N_REQ requesters onto the RTC multiplexed address/data bus,
// running one address/turnaround/data/recovery cycle per grant.
module rtc_bus_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned T_ADDR  = 4,
   parameter int unsigned T_DATA  = 4,
   parameter int unsigned T_REC   = 2,
   parameter int unsigned RR_MODE = 0
) (
   input  logic                      clk,
   input  logic                      Reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_we,
   input  logic [N_REQ*DATA_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          ack,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rd_valid,
   output logic                      busy,
   output logic [DATA_W-1:0]         ad_out,
   output logic                      ad_oe,
   input  logic [DATA_W-1:0]         ad_in,
   output logic                      ChipSelect,
   output logic                      Read,
   output logic                      Write,
   output logic                      AoD
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned T_MAX = (T_ADDR > T_DATA) ? ((T_ADDR > T_REC) ? T_ADDR : T_REC)
                                                     : ((T_DATA > T_REC) ? T_DATA : T_REC);
   localparam int unsigned CNT_W = $clog2(T_MAX + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_TURN = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_REC  = 3'd4;

   logic [2:0]        state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  ptr, ptr_n;
   logic [IDX_W-1:0]  cur_idx, idx_n;
   logic              cur_we, we_n;
   logic [DATA_W-1:0] cur_addr, addr_n;
   logic [DATA_W-1:0] cur_wdata, wdata_n;

   logic [N_REQ-1:0]  ack_n;
   logic [DATA_W-1:0] rd_data_n, ad_out_n;
   logic              rd_valid_n, busy_n, ad_oe_n, cs_n, rd_n, wr_n, aod_n;

   logic              grant_any;
   logic [IDX_W-1:0]  grant_idx;
   logic [DATA_W-1:0] addr_arr  [N_REQ];
   logic [DATA_W-1:0] wdata_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*DATA_W +: DATA_W];
      assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
   end

   // Winner search: scan from index 0, or from the round-robin pointer.
   always_comb begin
      int unsigned      cand;
      logic [IDX_W-1:0] cand_idx;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand     = (RR_MODE != 0) ? ((32'(ptr) + i) % N_REQ) : i;
         cand_idx = IDX_W'(cand);
         if (!grant_any && req[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   // Next state, then registered outputs derived from the next state.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      ptr_n      = ptr;
      idx_n      = cur_idx;
      we_n       = cur_we;
      addr_n     = cur_addr;
      wdata_n    = cur_wdata;
      ack_n      = '0;
      rd_valid_n = 1'b0;
      rd_data_n  = rd_data;
      cs_n       = 1'b1;
      rd_n       = 1'b1;
      wr_n       = 1'b1;
      aod_n      = 1'b1;
      ad_oe_n    = 1'b0;
      ad_out_n   = '0;

      case (state)
         S_IDLE: begin
            if (grant_any) begin
               state_n = S_ADDR;
               cnt_n   = '0;
               idx_n   = grant_idx;
               we_n    = req_we[grant_idx];
               addr_n  = addr_arr[grant_idx];
               wdata_n = wdata_arr[grant_idx];
               ptr_n   = IDX_W'((32'(grant_idx) + 32'd1) % N_REQ);
            end
         end
         S_ADDR: begin
            if (cnt == CNT_W'(T_ADDR - 1)) begin
               state_n = S_TURN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_TURN: begin
            state_n = S_DATA;
            cnt_n   = '0;
         end
         S_DATA: begin
            if (cnt == CNT_W'(T_DATA - 1)) begin
               state_n        = S_REC;
               cnt_n          = '0;
               ack_n[cur_idx] = 1'b1;
               rd_valid_n     = ~cur_we;
               if (!cur_we) rd_data_n = ad_in;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_REC: begin
            if (cnt == CNT_W'(T_REC - 1)) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase

      case (state_n)
         S_ADDR: begin
            cs_n     = 1'b0;
            aod_n    = 1'b0;
            ad_oe_n  = 1'b1;
            ad_out_n = addr_n;
         end
         S_TURN: begin
            cs_n     = 1'b0;
            ad_oe_n  = we_n;
            ad_out_n = we_n ? wdata_n : '0;
         end
         S_DATA: begin
            cs_n = 1'b0;
            if (we_n) begin
               wr_n     = 1'b0;
               ad_oe_n  = 1'b1;
               ad_out_n = wdata_n;
            end else begin
               rd_n = 1'b0;
            end
         end
         default: ;
      endcase

      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         ptr        <= '0;
         cur_idx    <= '0;
         cur_we     <= 1'b0;
         cur_addr   <= '0;
         cur_wdata  <= '0;
         ack        <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         busy       <= 1'b0;
         ad_oe      <= 1'b0;
         ad_out     <= '0;
         ChipSelect <= 1'b1;
         Read       <= 1'b1;
         Write      <= 1'b1;
         AoD        <= 1'b1;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         ptr        <= ptr_n;
         cur_idx    <= idx_n;
         cur_we     <= we_n;
         cur_addr   <= addr_n;
         cur_wdata  <= wdata_n;
         ack        <= ack_n;
         rd_valid   <= rd_valid_n;
         rd_data    <= rd_data_n;
         busy       <= busy_n;
         ad_oe      <= ad_oe_n;
         ad_out     <= ad_out_n;
         ChipSelect <= cs_n;
         Read       <= rd_n;
         Write      <= wr_n;
         AoD        <= aod_n;
      end
   end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: a fixed-priority instance and a
// round-robin instance sharing the bus-side inputs.
module tb_rtc_bus_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        Reset;
   logic [3:0]  req, req1, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [7:0]  ad_in;

   logic [3:0]  ack0, ack1;
   logic [7:0]  rd_data0, rd_data1, ad_out0, ad_out1;
   logic        rd_valid0, rd_valid1, busy0, busy1, ad_oe0, ad_oe1;
   logic        cs0, cs1, rd0, rd1, wr0, wr1, aod0, aod1;

   localparam logic [31:0] ADDRS = {8'h2A, 8'h21, 8'h22, 8'h20};
   localparam logic [31:0] WDATS = {8'hD3, 8'h59, 8'hB1, 8'hA0};

   rtc_bus_arbiter #(.RR_MODE(0)) dut0 (
      .clk(clk), .Reset(Reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack0), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .busy(busy0), .ad_out(ad_out0), .ad_oe(ad_oe0), .ad_in(ad_in),
      .ChipSelect(cs0), .Read(rd0), .Write(wr0), .AoD(aod0));

   rtc_bus_arbiter #(.RR_MODE(1)) dut1 (
      .clk(clk), .Reset(Reset), .req(req1), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack1), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .busy(busy1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in),
      .ChipSelect(cs1), .Read(rd1), .Write(wr1), .AoD(aod1));

   typedef struct {
      logic [3:0] req;
      logic [3:0] we;
      logic [7:0] ad_in;
      logic [3:0] exp_ack;
      logic [7:0] exp_addr;
      logic [7:0] exp_wdata;
      logic       exp_we;
      logic [7:0] exp_rd;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ack(input bit sel, input logic [3:0] exp, input string name);
      logic [3:0] a;
      a = '0;
      for (int i = 0; i < 40 && a == 4'b0; i++) begin
         @(negedge clk);
         a = sel ? ack1 : ack0;
      end
      chk(name, 32'(a), 32'(exp));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30 && (busy0 || busy1); i++) @(negedge clk);
      chk("idle", 32'({busy0, busy1}), 32'd0);
   endtask

   // One full transaction on the fixed-priority instance, checked cycle by cycle.
   task automatic run_txn(input vec_t v, input int n);
      logic [5:0] ec;
      req    = v.req;
      req_we = v.we;
      ad_in  = 8'hEE;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k <= 4)       ec = 6'b011011;
         else if (k == 5)  ec = {4'b0111, v.exp_we, 1'b1};
         else if (k <= 9)  ec = v.exp_we ? 6'b010111 : 6'b001101;
         else if (k <= 11) ec = 6'b111101;
         else              ec = 6'b111100;
         chk($sformatf("v%0d k%0d ctrl", n, k), 32'({cs0, rd0, wr0, aod0, ad_oe0, busy0}), 32'(ec));
         chk($sformatf("v%0d k%0d ack", n, k), 32'(ack0), (k == 10) ? 32'(v.exp_ack) : 32'd0);
         if (k == 1 || k == 4)
            chk($sformatf("v%0d k%0d addr", n, k), 32'(ad_out0), 32'(v.exp_addr));
         if (v.exp_we && (k == 5 || k == 9))
            chk($sformatf("v%0d k%0d wdata", n, k), 32'(ad_out0), 32'(v.exp_wdata));
         if (k == 10) begin
            chk($sformatf("v%0d rd_valid", n), 32'(rd_valid0), 32'(!v.exp_we));
            chk($sformatf("v%0d rd_data", n), 32'(rd_data0), 32'(v.exp_rd));
         end
         if (k == 13) chk($sformatf("v%0d rd_hold", n), 32'(rd_data0), 32'(v.exp_rd));
         if (k == 1) begin
            req       = 4'b0;
            req_addr  = ~ADDRS;
            req_wdata = ~WDATS;
         end
         if (k == 5)  ad_in = v.ad_in;
         if (k == 10) ad_in = 8'hEE;
         if (k == 12) begin
            req_addr  = ADDRS;
            req_wdata = WDATS;
         end
      end
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{4'b0100, 4'b0100, 8'h00, 4'b0100, 8'h21, 8'h59, 1'b1, 8'h00};
      vecs[1] = '{4'b0010, 4'b0000, 8'h37, 4'b0010, 8'h22, 8'hB1, 1'b0, 8'h37};
      vecs[2] = '{4'b1000, 4'b0000, 8'hC5, 4'b1000, 8'h2A, 8'hD3, 1'b0, 8'hC5};
      vecs[3] = '{4'b1111, 4'b0001, 8'h11, 4'b0001, 8'h20, 8'hA0, 1'b1, 8'hC5};
      vecs[4] = '{4'b1010, 4'b1000, 8'h5A, 4'b0010, 8'h22, 8'hB1, 1'b0, 8'h5A};
      vecs[5] = '{4'b1100, 4'b1100, 8'h66, 4'b0100, 8'h21, 8'h59, 1'b1, 8'h5A};
      vecs[6] = '{4'b0011, 4'b0010, 8'h00, 4'b0001, 8'h20, 8'hA0, 1'b0, 8'h00};

      Reset     = 1'b0;
      req       = 4'b0;
      req1      = 4'b0;
      req_we    = 4'b0;
      req_addr  = ADDRS;
      req_wdata = WDATS;
      ad_in     = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset ctrl0", 32'({cs0, rd0, wr0, aod0, ad_oe0, busy0, rd_valid0}), 32'b1111000);
      chk("reset ack0", 32'(ack0), 32'd0);
      chk("reset ad_out0", 32'(ad_out0), 32'd0);
      chk("reset rd_data0", 32'(rd_data0), 32'd0);
      chk("reset ctrl1", 32'({cs1, rd1, wr1, aod1, ad_oe1, busy1, rd_valid1}), 32'b1111000);
      Reset = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 7; n++) run_txn(vecs[n], n);

      // Fixed priority: ch1 held keeps winning, ch3 waits until ch1 drops.
      req    = 4'b1010;
      req_we = 4'b0000;
      for (int i = 0; i < 3; i++) wait_ack(1'b0, 4'b0010, $sformatf("starve ch1 #%0d", i));
      req = 4'b1000;
      wait_ack(1'b0, 4'b1000, "starve ch3");
      req = 4'b0;
      wait_idle();

      // Round-robin instance alternates between the two held requests.
      req1 = 4'b1010;
      wait_ack(1'b1, 4'b0010, "rr grant 1a");
      wait_ack(1'b1, 4'b1000, "rr grant 3a");
      wait_ack(1'b1, 4'b0010, "rr grant 1b");
      wait_ack(1'b1, 4'b1000, "rr grant 3b");
      req1 = 4'b0;
      wait_idle();

      // Reset in the second DATA cycle of a write aborts it.
      req    = 4'b0100;
      req_we = 4'b0100;
      repeat (7) @(negedge clk);
      chk("abort wr low", 32'(wr0), 32'd0);
      Reset = 1'b0;
      @(negedge clk);
      chk("abort released", 32'({wr0, cs0, ad_oe0, busy0}), 32'b1100);
      chk("abort no ack", 32'(ack0), 32'd0);
      Reset = 1'b1;
      @(negedge clk);
      chk("abort restart ctrl", 32'({cs0, aod0, busy0}), 32'b001);
      chk("abort restart addr", 32'(ad_out0), 32'h21);
      wait_ack(1'b0, 4'b0100, "abort restart ack");
      req = 4'b0;
      wait_idle();

      // Back-to-back on ch0: drop after ack, re-assert during recovery.
      req    = 4'b0001;
      req_we = 4'b0000;
      wait_ack(1'b0, 4'b0001, "b2b first ack");
      req = 4'b0;
      @(negedge clk);
      req = 4'b0001;
      chk("b2b rec busy", 32'(busy0), 32'd1);
      @(negedge clk);
      chk("b2b idle gap", 32'(busy0), 32'd0);
      @(negedge clk);
      chk("b2b regrant", 32'({busy0, cs0}), 32'b10);
      wait_ack(1'b0, 4'b0001, "b2b second ack");
      req = 4'b0;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Parametrised successor to the fixed address/data steering in the clock top level.
- Arbitrates N_REQ requesters (init, write, periodic read, reset loader, chrono, ...) for the RTC's multiplexed address/data bus.
- Runs one complete bus cycle per grant: address phase, turnaround, data phase, recovery.
- Generates ChipSelect/Read/Write/AoD and returns read data. It replaces per-source muxing and the single-cycle-style protocol unit.

Parameters:
N_REQ, 4, number of requesters; index 0 = highest fixed priority
DATA_W, 8, address and data width on the shared bus
T_ADDR, 4, cycles of address phase (>=1)
T_DATA, 4, cycles of Read/Write strobe low (>=1)
T_REC, 2, recovery cycles, all strobes high (>=1)
RR_MODE, 0, 0 = fixed priority; 1 = round-robin

Ports:
clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
req  in  N_REQ  request per channel; held high until ack
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*DATA_W  packed RTC register address, channel i at [i*DATA_W +: DATA_W]
req_wdata  in  N_REQ*DATA_W  packed write data
ack  out  N_REQ  one-hot, one-cycle pulse when channel's transaction completes
rd_data  out  DATA_W  data captured on last read
rd_valid  out  1  one-cycle pulse with ack for reads
busy  out  1  high in any state except IDLE
ad_out  out  DATA_W  bus drive value (top-level tristate)
ad_oe  out  1  bus output enable
ad_in  in  DATA_W  bus sampled value
ChipSelect, Read, Write, AoD  out  1 each  active-low RTC controls; AoD=0 address, 1 data

Behaviour:
- Reset (Reset=0 at clock edge):
  - State -> IDLE.
  - ack=0, rd_valid=0, busy=0, ad_oe=0, ad_out=0, rd_data=0.
  - ChipSelect=Read=Write=AoD=1.
  - RR pointer=0.
  - Reset asserted mid-transaction aborts it. No ack, bus released on the next edge.
- IDLE:
  - If any req is high, the arbiter picks a winner at this edge.
  - Winner's we, addr and wdata are latched into internal registers. Later changes to req inputs are ignored until the transaction completes.
  - Next state is ADDR.
- Arbitration:
  - RR_MODE=0: lowest asserted index wins.
  - RR_MODE=1: first asserted index at or after the pointer, wrapping N_REQ-1 -> 0. The pointer becomes winner+1 (mod N_REQ) on grant.
- ADDR, T_ADDR cycles: ChipSelect=0, AoD=0, ad_oe=1, ad_out=latched addr.
- TURN, 1 cycle: AoD=1, ChipSelect=0, Read=Write=1.
  - Write: ad_oe=1, ad_out=wdata.
  - Read: ad_oe=0.
- DATA, T_DATA cycles: ChipSelect=0, AoD=1.
  - Write: Write=0, ad_oe=1, ad_out=wdata.
  - Read: Read=0, ad_oe=0.
  - For reads, ad_in is captured into rd_data at the edge ending the last DATA cycle.
- REC, T_REC cycles: all controls high, ad_oe=0.
  - On REC entry, ack[winner] pulses for 1 cycle; rd_valid pulses with it for reads.
  - After the final REC cycle the state returns to IDLE.
- Timing:
  - Transaction length T_ADDR+1+T_DATA+T_REC cycles; 11 with defaults.
  - IDLE lasts at least 1 cycle between transactions, so the next grant comes at the earliest 1 cycle after REC ends.
- Requester contract:
  - A requester must drop req in the cycle after ack or it is re-granted.
  - Dropping req mid-transaction does not abort; ack still pulses.
- rd_data holds its value until the next read capture or Reset.
- ad_oe is never 1 while Read=0, so there is no bus contention.
- Phase counter width is clog2 of max(T_ADDR, T_DATA, T_REC)+1. Wrap is not possible.

Test Plan:
- Write ch2, addr 0x21, data 0x59 (RR_MODE=0):
  - ADDR 4 cycles with ad_out=0x21, AoD=0, ChipSelect=0.
  - TURN 1 cycle, then Write=0 for 4 cycles with ad_out=0x59.
  - ack=0b0100 exactly 10 cycles after the ADDR start; rd_valid=0.
- Read ch1, addr 0x22, ad_in=0x37 during DATA:
  - ad_oe=0 and Read=0 for 4 cycles.
  - rd_data=0x37 with rd_valid=1 and ack=0b0010 in the same cycle.
- req=0b1010 held continuously, RR_MODE=0: ch1 served repeatedly and ch3 starves until ch1 drops. With RR_MODE=1: grants alternate 1,3,1,3.
- Reset=0 during the 2nd DATA cycle of a write: next edge gives Write=1, ChipSelect=1, ad_oe=0, busy=0, no ack. After Reset=1 the held req restarts from ADDR.
- Back-to-back: ch0 drops req after ack, ch0 re-asserts within REC. The new grant occurs at the first IDLE edge; busy low exactly 1 cycle.
- Ch3 drops req during ADDR: transaction completes, ack=0b1000 still pulses, no further grant.
